// File: rtl/imm_ext_buf_if.sv
`default_nettype none
//==============================================================================
// imm_ext_buf_if -- request/response bundle for imm_ext_buf.  Rev 1.0
//==============================================================================
interface imm_ext_buf_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int J_W   = 26
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  imm_i;
  logic [J_W-1:0]   jidx_i;
  logic [OUT_W-1:0] pc_i;
  logic [2:0]       mode_i;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] ext_o;
  logic             err_o;

  modport master (
    output in_valid, imm_i, jidx_i, pc_i, mode_i, out_ready,
    input  in_ready, out_valid, ext_o, err_o
  );

  modport slave (
    input  in_valid, imm_i, jidx_i, pc_i, mode_i, out_ready,
    output in_ready, out_valid, ext_o, err_o
  );
endinterface
`default_nettype wire

// File: rtl/imm_ext_buf.sv
`default_nettype none
//==============================================================================
// imm_ext_buf -- immediate extension into a 2-entry skid buffer; jump mode
// (mode 4) compiled in by IMM_EXT_JUMP_EN.  Rev 1.0
//==============================================================================
module imm_ext_buf #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int J_W   = 26
) (
  input  wire logic    clk,
  input  wire logic    rst_n,
  imm_ext_buf_if.slave bus
);

  localparam int PAD_W = OUT_W - IN_W;

  if (OUT_W <= IN_W + 2) begin : g_chk_in_w
    $error("imm_ext_buf: OUT_W must exceed IN_W + 2");
  end
`ifdef IMM_EXT_JUMP_EN
  if (OUT_W <= J_W + 2) begin : g_chk_j_w
    $error("imm_ext_buf: OUT_W must exceed J_W + 2");
  end
`endif

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [OUT_W-1:0] head_q, head_d;
  logic [OUT_W-1:0] tail_q, tail_d;
  logic             in_ready_q;
  logic             err_q;

  logic [OUT_W-1:0] w_sext;
  logic [OUT_W-1:0] w_word;
  logic             w_illegal;
  logic             w_acc;
  logic             w_pop;

  assign w_sext = {{PAD_W{bus.imm_i[IN_W-1]}}, bus.imm_i};

  always_comb begin
    w_word    = '0;
    w_illegal = 1'b0;
    case (bus.mode_i)
      3'd0: w_word = {{PAD_W{1'b0}}, bus.imm_i};
      3'd1: w_word = {bus.imm_i, {PAD_W{1'b0}}};
      3'd2: w_word = w_sext;
      3'd3: w_word = {w_sext[OUT_W-3:0], 2'b00};
`ifdef IMM_EXT_JUMP_EN
      3'd4: w_word = {bus.pc_i[OUT_W-1:J_W+2], bus.jidx_i, 2'b00};
`endif
      default: w_illegal = 1'b1;
    endcase
  end

`ifndef IMM_EXT_JUMP_EN
  logic w_unused_jump;
  assign w_unused_jump = ^{bus.pc_i, bus.jidx_i};
`endif

  assign w_acc = bus.in_valid & in_ready_q;
  assign w_pop = (state_q != EMPTY) & bus.out_ready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      EMPTY: begin
        if (w_acc) begin
          head_d  = w_word;
          state_d = ONE;
        end
      end
      ONE: begin
        if (w_acc && w_pop) begin
          head_d = w_word;
        end else if (w_acc) begin
          tail_d  = w_word;
          state_d = TWO;
        end else if (w_pop) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        // in_ready is low here, so only a pop can happen
        if (w_pop) begin
          head_d  = tail_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      head_q     <= '0;
      tail_q     <= '0;
      in_ready_q <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      in_ready_q <= (state_d != TWO);
      err_q      <= err_q | (w_acc & w_illegal);
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = (state_q != EMPTY);
  assign bus.ext_o     = head_q;
  assign bus.err_o     = err_q;

endmodule
`default_nettype wire
